// File: rtl/ft601_pkg.sv
// Shared constants and FSM state type for the FT601 write-side packetiser.
package ft601_pkg;

  localparam logic [7:0] HDR_SYNC = 8'hA5;
  localparam logic [7:0] TRL_SYNC = 8'h5A;
  localparam logic [3:0] BE_ALL   = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    TRAILER,
    PUSH,
    DRAIN
  } wr_arb_state_t;

endpackage

// File: rtl/ft601_rr_arb.sv
// Combinational round-robin picker: first requester strictly after last_grant, wrapping.
module ft601_rr_arb #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [3:0]         last_grant,
  output logic [3:0]         gnt_id,
  output logic               any_req
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int PW = IW + 1;

  logic [PW-1:0] idx;
  logic          found;

  // last_grant + k stays below 2*NUM_SRC, so one conditional subtract wraps it.
  always_comb begin
    gnt_id = last_grant;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = PW'(last_grant) + PW'(k);
      if (idx >= PW'(NUM_SRC)) idx = idx - PW'(NUM_SRC);
      if (!found && req[idx[IW-1:0]]) begin
        gnt_id = 4'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ft601_wr_arb.sv
// Round-robin packetiser: frames one granted stream per burst (header, payload, trailer, push)
// into the FT601 write buffer.
module ft601_wr_arb
  import ft601_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int BURST_LEN = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [32*NUM_SRC-1:0]  s_data,
  input  logic [NUM_SRC-1:0]     s_valid,
  input  logic [NUM_SRC-1:0]     s_last,
  output logic [NUM_SRC-1:0]     s_ready,
  output logic [35:0]            wr_data,
  output logic                   wr_en,
  output logic                   wr_ce,
  output logic                   wr_push,
  input  logic                   wr_busy,
  output logic [3:0]             grant_id,
  output logic                   busy_o
);

  localparam logic [15:0] BLEN = 16'(BURST_LEN);

  wr_arb_state_t            state_q, state_d;
  logic [3:0]               grant_q, grant_d;
  logic [3:0]               last_q, last_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [NUM_SRC-1:0][3:0]  seq_q, seq_d;
  logic [35:0]              wr_data_q, wr_data_d;
  logic                     wr_en_q, wr_en_d;
  logic                     wr_push_q, wr_push_d;
  logic                     wr_ce_q;
  logic                     busy_q, busy_d;

  logic [3:0]               arb_gnt;
  logic                     any_req;
  logic [31:0]              cur_data;
  logic                     cur_valid, cur_last;
  logic [3:0]               cur_seq;
  logic                     can_take, accept;

  ft601_rr_arb #(.NUM_SRC(NUM_SRC)) u_rr (
    .req        (s_valid),
    .last_grant (last_q),
    .gnt_id     (arb_gnt),
    .any_req    (any_req)
  );

  // Select the granted stream; s_ready is the only combinational output.
  always_comb begin
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_seq   = '0;
    s_ready   = '0;
    can_take  = (state_q == PAYLOAD) && !wr_busy && (cnt_q < BLEN);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == 4'(i)) begin
        cur_data   = s_data[32*i +: 32];
        cur_valid  = s_valid[i];
        cur_last   = s_last[i];
        cur_seq    = seq_q[i];
        s_ready[i] = can_take;
      end
    end
    accept = can_take && cur_valid;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    wr_push_d = 1'b0;
    case (state_q)
      IDLE: if (any_req && !wr_busy) begin
        grant_d = arb_gnt;
        cnt_d   = '0;
        state_d = HDR;
      end
      HDR: if (!wr_busy) begin
        wr_en_d   = 1'b1;
        wr_data_d = {BE_ALL, HDR_SYNC, grant_q, cur_seq, 16'h0000};
        state_d   = PAYLOAD;
      end
      PAYLOAD: if (accept) begin
        wr_en_d   = 1'b1;
        wr_data_d = {BE_ALL, cur_data};
        cnt_d     = cnt_q + 16'd1;
        if (cur_last || (cnt_q + 16'd1 == BLEN)) state_d = TRAILER;
      end
      TRAILER: if (!wr_busy) begin
        wr_en_d   = 1'b1;
        wr_data_d = {BE_ALL, TRL_SYNC, grant_q, cur_seq, cnt_q};
        state_d   = PUSH;
      end
      PUSH: begin
        wr_push_d = 1'b1;
        for (int i = 0; i < NUM_SRC; i++)
          if (grant_q == 4'(i)) seq_d[i] = seq_q[i] + 4'd1;
        state_d = DRAIN;
      end
      // Ignore wr_busy while the push is still on the wire; the buffer raises it a cycle later.
      DRAIN: if (!wr_push_q && !wr_busy) begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= 4'(NUM_SRC - 1);
      cnt_q     <= '0;
      seq_q     <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      wr_push_q <= 1'b0;
      wr_ce_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      seq_q     <= seq_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      wr_push_q <= wr_push_d;
      wr_ce_q   <= 1'b1;
      busy_q    <= busy_d;
    end
  end

  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign wr_push  = wr_push_q;
  assign wr_ce    = wr_ce_q;
  assign grant_id = grant_q;
  assign busy_o   = busy_q;

endmodule
